// File: rtl/boxcar_decimator_if.sv
// rtl/boxcar_decimator_if.sv - sample stream and averaged output bundle for boxcar_decimator
interface boxcar_decimator_if #(
  parameter int W      = 16,
  parameter int LOG2_N = 3
);
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;

  logic signed [W-1:0]  d;
  logic                 d_valid;
  logic                 clr;
  logic signed [W-1:0]  q;
  logic                 q_valid;
  logic        [CW-1:0] cnt;

  modport master (
    output d, d_valid, clr,
    input  q, q_valid, cnt
  );

  modport slave (
    input  d, d_valid, clr,
    output q, q_valid, cnt
  );
endinterface

// File: rtl/boxcar_decimator.sv
// rtl/boxcar_decimator.sv - accumulate-and-dump block averager, N = 2^LOG2_N samples per output
module boxcar_decimator #(
  parameter int W      = 16,
  parameter int LOG2_N = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  boxcar_decimator_if.slave   bus
);
  localparam int AW = W + LOG2_N;
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int N  = 1 << LOG2_N;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic signed [AW-1:0] acc_q, acc_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic signed [W-1:0]  q_q, q_d;
  logic                 q_valid_q, q_valid_d;
  logic signed [AW-1:0] sum;

  // AW bits hold the exact sum of N full-scale samples, so no overflow handling is needed
  assign sum = acc_q + AW'(bus.d);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    if (bus.clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bus.d_valid) begin
      if (cnt_q == CNT_LAST) begin
        q_d       = W'(sum >>> LOG2_N);
        q_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.cnt     = cnt_q;
endmodule

// File: tb/tb_boxcar_decimator.sv
// tb/tb_boxcar_decimator.sv - scoreboard bench for boxcar_decimator with W=16, LOG2_N=3
module tb_boxcar_decimator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   m_cnt = 0;

  typedef struct {
    logic signed [15:0] q;
    int                 cyc;
  } exp_t;
  exp_t sb[$];

  boxcar_decimator_if #(.W(16), .LOG2_N(3)) bus ();

  boxcar_decimator #(.W(16), .LOG2_N(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops on each strobe, otherwise checks q is held
  logic signed [15:0] hold = 16'sd0;
  always @(negedge clk) begin
    if (!reset_n) begin
      hold = 16'sd0;
    end else if (bus.q_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got q=%0d at cycle %0d, none expected", bus.q, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.q !== e.q || cyc != e.cyc) begin
          fails++;
          $display("FAIL strobe: got q=%0d cycle=%0d, expected q=%0d cycle=%0d",
                   bus.q, cyc, e.q, e.cyc);
        end
        hold = e.q;
      end
    end else begin
      tests++;
      if (bus.q !== hold) begin
        fails++;
        $display("FAIL q_hold: got q=%0d, expected %0d at cycle %0d", bus.q, hold, cyc);
      end
    end
  end

  task automatic check_cnt();
    tests++;
    if (bus.cnt !== 3'(m_cnt)) begin
      fails++;
      $display("FAIL cnt: got %0d, expected %0d at cycle %0d", bus.cnt, m_cnt, cyc);
    end
  endtask

  task automatic step(input logic signed [15:0] dv, input logic v, input logic c);
    @(posedge clk);
    #1;
    check_cnt();
    bus.d = dv;
    bus.d_valid = v;
    bus.clr = c;
    if (c) m_cnt = 0;
    else if (v) m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
  endtask

  task automatic expect_q(input logic signed [15:0] v);
    exp_t e;
    e.q = v;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(16'sh7FFF, 1'b0, 1'b0);
  endtask

  task automatic block_const(input logic signed [15:0] v, input logic signed [15:0] avg);
    for (int i = 0; i < 8; i++) step(v, 1'b1, 1'b0);
    expect_q(avg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.d = '0;
    bus.d_valid = 1'b0;
    bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.q !== 16'sd0 || bus.q_valid !== 1'b0 || bus.cnt !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: got q=%0d q_valid=%0b cnt=%0d, expected 0 0 0",
               bus.q, bus.q_valid, bus.cnt);
    end
    reset_n = 1'b1;

    block_const(16'sd1000, 16'sd1000);
    idle(); idle();

    for (int i = 0; i < 8; i++) step(16'(-8 + i), 1'b1, 1'b0);
    expect_q(-16'sd5);
    for (int i = 0; i < 8; i++) step(16'(i), 1'b1, 1'b0);
    expect_q(16'sd3);
    idle();

    block_const(-16'sd32768, -16'sd32768);
    block_const(16'sd32767, 16'sd32767);
    idle();

    for (int i = 0; i < 8; i++) begin
      step(16'sd200, 1'b1, 1'b0);
      if (i == 7) expect_q(16'sd200);
      idle(); idle();
    end

    for (int i = 0; i < 5; i++) step(16'sd5000, 1'b1, 1'b0);
    step(16'sd5000, 1'b1, 1'b1);
    idle();
    block_const(16'sd100, 16'sd100);
    idle(); idle();

    for (int i = 0; i < 4; i++) step(16'sd777, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    bus.d_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    m_cnt = 0;
    tests++;
    if (bus.q !== 16'sd0 || bus.q_valid !== 1'b0 || bus.cnt !== 3'd0) begin
      fails++;
      $display("FAIL async_reset: got q=%0d q_valid=%0b cnt=%0d, expected 0 0 0",
               bus.q, bus.q_valid, bus.cnt);
    end
    #4;
    reset_n = 1'b1;
    block_const(-16'sd300, -16'sd300);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
    idle(); idle();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_strobes: %0d outputs never seen, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/boxcar_decimator.md
Name: boxcar_decimator

Overview:
- Block-average (accumulate-and-dump) decimator that sits directly upstream of the exponential averaging filter.
- Accumulates N = 2^LOG2_N valid input samples and emits one averaged sample per block.
- This reduces the sample rate, and the noise bandwidth, seen by the IIR averager.
- Output is a held register plus a one-cycle valid strobe, so the downstream filter can be clock-enabled by q_valid.

Parameters:
W, 16, sample width (signed two's complement) for d and q
LOG2_N, 3, log2 of block length N; legal range 0..8 (N = 1..256)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
d  input  W  signed input sample
d_valid  input  1  d is accepted on this rising edge when high
clr  input  1  synchronous block restart: discards partial accumulation
q  output  W  signed block average, held between strobes
q_valid  output  1  one-cycle pulse: q updated this cycle
cnt  output  max(LOG2_N,1)  number of samples in current partial block (debug/status)

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-block): acc=0, cnt=0, q=0, q_valid=0. First block after reset release starts empty.
- Internal accumulator acc: signed, W+LOG2_N bits. It holds the exact sum of up to N samples, so overflow is impossible. No saturation logic is used.
- Per rising edge, the priority is clr > d_valid.
- clr=1: acc<=0, cnt<=0, q_valid<=0, q unchanged. A d_valid sample in the same cycle is dropped.
- clr=0, d_valid=1, cnt<N-1:
  - acc <= acc + sext(d)
  - cnt <= cnt+1
  - q_valid <= 0
- clr=0, d_valid=1, cnt==N-1 (block-completing sample):
  - sum = acc + sext(d)
  - q <= sum >>> LOG2_N (arithmetic shift, floor rounding toward -inf), taking the low W bits, which are always in range
  - q_valid <= 1
  - acc <= 0
  - cnt <= 0
- clr=0, d_valid=0: acc and cnt hold, q_valid <= 0, q holds.
- Latency: q/q_valid appear on the edge after the Nth accepted sample is sampled, i.e. 1 clock after that sample's d_valid cycle.
- q_valid is never high on two consecutive cycles unless N=1 and d_valid is continuous.
- Gaps in d_valid of any length are allowed. Only accepted samples count.
- LOG2_N=0: every valid sample passes through with 1-cycle latency (q=d, q_valid=d_valid & ~clr); cnt stays 0.
- cnt wraps N-1 -> 0 only via block completion. It never reaches N.
- Mid-block clr or reset leaves no residue; the next output averages exactly the next N accepted samples.
- No backpressure: the downstream stage must accept every q_valid strobe.

Test Plan:
- Reset, then 8 consecutive valid samples of 1000 (LOG2_N=3) -> after 8th, exactly one q_valid pulse with q=1000; cnt counts 0..7 then returns to 0.
- Samples -8,-7,...,-1 (sum -36) -> q=-5 (floor of -4.5). Ramp 0..7 (sum 28) -> q=3.
- Extremes: 8 x -32768 -> q=-32768; 8 x 32767 -> q=32767; no wrap.
- d_valid asserted every 3rd cycle with value 200 -> q_valid only after 8th accepted sample; q=200; q held between strobes; non-valid d values (e.g. 0x7FFF) ignored.
- 5 samples of 5000, then clr concurrent with a 6th valid sample, then 8 samples of 100 -> q=100 (clr wins, sample dropped); no q_valid from the aborted block; q keeps previous value until then.
- reset_n pulsed low asynchronously (between edges) after 4 samples -> q=0, q_valid=0, cnt=0 immediately; next 8 samples of -300 -> q=-300.
